// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-timing helper
// that uart_tx and uart_rx both use, so the two ends agree on bit length.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } uart_state_e;

   // Wide enough to index up to 9 payload bits.
   localparam int IDX_W = 4;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver: half_tick marks mid start bit,
// full_tick marks every bit boundary after a clear.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 5625
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic half_tick,
   output logic full_tick
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear || full_tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign half_tick = (cnt_q == CNT_W'(HALF_BIT - 1));
   assign full_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, 8N1 framing.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE = 4800,
   parameter int DATA_BITS = 8,
   parameter int CLK_FREQ  = 27_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_update,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

   uart_state_e          state_q, state_d;
   logic                 rx_meta, rx_s;
   logic                 tmr_clear, half_tick, full_tick;
   logic                 sample_bit, accept, reject, par_bad;
   logic [IDX_W-1:0]     bit_idx_q;
   logic [DATA_BITS-1:0] shift_q, data_q;
   logic                 data_update_q, frame_error_q;

   // Synchroniser resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (tmr_clear),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

`ifdef UART_RX_PARITY_EN
   logic sample_par;
   logic par_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q <= 1'b0;
      end else if (state_q == START) begin
         par_err_q <= 1'b0;
      end else if (sample_par) begin
         par_err_q <= ^{shift_q, rx_s};
      end
   end

   assign par_bad = par_err_q;
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      tmr_clear  = 1'b0;
      sample_bit = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
`ifdef UART_RX_PARITY_EN
      sample_par = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            tmr_clear = 1'b1;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (half_tick) begin
               tmr_clear = 1'b1;
               state_d   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (full_tick) begin
               sample_bit = 1'b1;
               if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (full_tick) begin
               sample_par = 1'b1;
               state_d    = STOP;
            end
         end
`endif
         STOP: begin
            if (full_tick) begin
               if (!rx_s) begin
                  reject  = 1'b1;
                  state_d = WAIT_IDLE;
               end else if (par_bad) begin
                  reject  = 1'b1;
                  state_d = IDLE;
               end else begin
                  accept  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q       <= '0;
         bit_idx_q     <= '0;
         data_q        <= '0;
         data_update_q <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         data_update_q <= accept;
         frame_error_q <= reject;
         if (state_q == START) begin
            bit_idx_q <= '0;
         end else if (sample_bit) begin
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + IDX_W'(1);
         end
         if (accept) data_q <= shift_q;
      end
   end

   assign data        = data_q;
   assign data_update = data_update_q;
   assign frame_error = frame_error_q;
   assign busy        = (state_q != IDLE) && (state_q != START);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit period (64 clocks per bit);
// define UART_RX_PARITY_EN on both bench and RTL to exercise the parity frames.
module tb_uart_rx;

   localparam int CLK_FREQ  = 307_200;
   localparam int BAUD_RATE = 4800;
   localparam int DATA_BITS = 8;
   localparam int CPB       = 64;

   logic                 clk;
   logic                 rst_n;
   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 data_update;
   logic                 frame_error;
   logic                 busy;

   int checks   = 0;
   int failures = 0;

   int                   upd_cnt     = 0;
   int                   fe_cnt      = 0;
   int                   overlap_cnt = 0;
   logic                 busy_seen   = 1'b0;
   logic [DATA_BITS-1:0] got_q[$];

   uart_rx #(
      .BAUD_RATE (BAUD_RATE),
      .DATA_BITS (DATA_BITS),
      .CLK_FREQ  (CLK_FREQ)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .data        (data),
      .data_update (data_update),
      .frame_error (frame_error),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor, sampling on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (data_update) begin
         upd_cnt++;
         got_q.push_back(data);
      end
      if (frame_error) fe_cnt++;
      if (data_update && frame_error) overlap_cnt++;
      if (busy) busy_seen = 1'b1;
   end

   initial begin
      #(50_000 * 10);
      $display("FAIL watchdog: simulation did not reach the end within 50000 cycles");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_bit(input logic v, input int n_bits);
      rx = v;
      repeat (n_bits * CPB) @(negedge clk);
   endtask

   task automatic send_payload(input logic [7:0] b);
      drive_bit(1'b0, 1);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i], 1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
      send_payload(b);
`ifdef UART_RX_PARITY_EN
      drive_bit(^b, 1);
`endif
      drive_bit(stop_val, stop_len);
      rx = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_parity_frame(input logic [7:0] b, input logic par_bit);
      send_payload(b);
      drive_bit(par_bit, 1);
      drive_bit(1'b1, 1);
   endtask
`endif

   initial begin
      int upd0;
      int fe0;
      logic [7:0] partial;

      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_data", 32'(data), 32'h0);
      check("reset_update", 32'(data_update), 32'h0);
      check("reset_frame_error", 32'(frame_error), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      busy_seen = 1'b0;

      // Single good frame.
      send_frame(8'hA5, 1'b1, 1);
      repeat (4) @(negedge clk);
      check("a5_update_count", 32'(upd_cnt), 32'd1);
      check("a5_data", 32'(data), 32'hA5);
      check("a5_no_frame_error", 32'(fe_cnt), 32'd0);
      check("a5_busy_seen", 32'(busy_seen), 32'h1);
      check("a5_busy_after_stop", 32'(busy), 32'h0);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      repeat (4) @(negedge clk);
      check("b2b_update_count", 32'(upd_cnt), 32'd3);
      check("b2b_first_word", 32'(got_q[1]), 32'h00);
      check("b2b_second_word", 32'(got_q[2]), 32'hFF);

      // Short low glitch, well under half a bit.
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_no_update", 32'(upd_cnt), 32'd3);
      check("glitch_no_frame_error", 32'(fe_cnt), 32'd0);
      check("glitch_busy_never", 32'(busy_seen), 32'h0);

      // Framing error: stop bit low, line held low for 3 bit times.
      send_payload(8'h3C);
`ifdef UART_RX_PARITY_EN
      drive_bit(1'b0, 1);
`endif
      drive_bit(1'b0, 3);
      check("fe_pulse_count", 32'(fe_cnt), 32'd1);
      check("fe_no_update", 32'(upd_cnt), 32'd3);
      check("fe_data_held", 32'(data), 32'hFF);
      check("fe_busy_while_low", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      check("fe_busy_after_high", 32'(busy), 32'h0);
      repeat (CPB) @(negedge clk);

      // Reset in the middle of the data bits of 0x5A.
      partial = 8'h5A;
      drive_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) drive_bit(partial[i], 1);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      check("midreset_busy", 32'(busy), 32'h0);
      check("midreset_data", 32'(data), 32'h0);
      rst_n = 1'b1;
      repeat (CPB) @(negedge clk);
      check("midreset_no_pulse", 32'(upd_cnt + fe_cnt), 32'd4);
      send_frame(8'h81, 1'b1, 1);
      repeat (4) @(negedge clk);
      check("after_reset_update", 32'(upd_cnt), 32'd4);
      check("after_reset_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
      upd0 = upd_cnt;
      fe0  = fe_cnt;
      send_parity_frame(8'h07, 1'b1);
      repeat (4) @(negedge clk);
      check("par_good_update", 32'(upd_cnt - upd0), 32'd1);
      check("par_good_data", 32'(data), 32'h07);
      check("par_good_no_fe", 32'(fe_cnt - fe0), 32'd0);
      send_parity_frame(8'h07, 1'b0);
      repeat (4) @(negedge clk);
      check("par_bad_frame_error", 32'(fe_cnt - fe0), 32'd1);
      check("par_bad_no_update", 32'(upd_cnt - upd0), 32'd1);
      check("par_bad_data_held", 32'(data), 32'h07);
`else
      upd0 = upd_cnt;
      fe0  = fe_cnt;
      check("final_counts", 32'(upd0 + fe0), 32'd5);
`endif

      check("never_update_and_error", 32'(overlap_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the existing uart_tx.
- Deserialises an asynchronous 8N1 serial line into parallel words on the system clock.
- Pulses data_update once per good frame, so the word can feed the SPI master or loop back to uart_tx.
- Sits at the board pin boundary. Owns input synchronisation, start-bit validation and framing checks.

Parameters:
- BAUD_RATE, 4800, serial bit rate in bit/s
- DATA_BITS, 8, payload bits per frame (5..9)
- CLK_FREQ, 27_000_000, clk frequency in Hz

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line; idle high; asynchronous to clk
- data  output  DATA_BITS  last correctly received word
- data_update  output  1  one-cycle pulse when data has been updated
- frame_error  output  1  one-cycle pulse on bad stop bit (or bad parity when enabled)
- busy  output  1  high from validated start bit until return to IDLE

Behaviour:
- Reset (async, rst_n low): data=0, data_update=0, frame_error=0, busy=0, state=IDLE. Both synchroniser flops are set to 1 (idle line).
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, so there are 2 cycles of input latency.
- Timing constants:
  - CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division (5625 at defaults).
  - HALF_BIT = CLKS_PER_BIT/2 (2812).
  - The bit counter is $clog2(CLKS_PER_BIT) bits wide and reloads to 0 on each bit boundary.
- IDLE:
  - busy=0.
  - rx_s==0 goes to START with the counter cleared. No edge detector is needed: a line held low from reset also starts, then fails framing.
- START:
  - When the counter reaches HALF_BIT-1, sample rx_s.
  - rx_s==0: busy=1, go to DATA with bit index 0 and the counter cleared.
  - rx_s==1 (glitch): back to IDLE with no pulse.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s at mid-bit into a shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if enabled, otherwise STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1 (and no parity error): data <= shift register and data_update=1 for exactly one cycle, the cycle after the sample. Go to IDLE.
  - rx_s==0: frame_error=1 for one cycle, data is unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Timing:
  - A frame is accepted 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT cycles after the falling edge on rx.
  - The receiver is back in IDLE half a bit before the nominal stop-bit end, which allows back-to-back frames and tolerates about ±4% baud mismatch.
- data_update and frame_error are never high in the same cycle.
- data holds its value between updates.
- Reset mid-frame aborts immediately with no pulse. After release, the receiver resynchronises on the next low level.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP, one bit period long.
  - Even parity over the DATA_BITS payload.
  - A mismatch is latched. The STOP state then signals frame_error and suppresses data_update even when the stop bit is good.
- UART_RX_PARITY_EN undefined: no PARITY state or logic; the frame is 8N1 only.

Decomposition:
- Shared package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Helper function clks_per_bit(CLK_FREQ, BAUD_RATE), shared with uart_tx so both ends agree on bit timing.
- One natural sub-module, uart_bit_timer: counter with clear input, producing half_tick and full_tick.
- The 2-flop synchroniser stays inline.

Test Plan:
- Default parameters, send 0xA5 as 8N1 at exactly 4800 baud -> one data_update pulse with data=0xA5, frame_error=0, busy falls after the stop-bit sample.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two data_update pulses; data=0x00 and then 0xFF.
- Send a 1000-cycle low glitch on rx (shorter than HALF_BIT) -> no pulses, busy stays 0, state returns to IDLE.
- Send a frame for 0x3C with the stop bit driven low, held low for 3 bit times -> frame_error one pulse, data keeps its previous value, no new frame accepted until rx returns high.
- Assert rst_n low midway through the data bits of 0x5A, release, then send 0x81 -> no pulse for the aborted frame; data=0x81 on the next update.
- With UART_RX_PARITY_EN defined, send 0x07:
  - with parity bit 1 -> data_update with data=0x07;
  - with parity bit 0 -> frame_error and no data_update.
